// File: rtl/store_write_buffer.sv
// store_write_buffer
//
// Post-commit store write buffer. Retired stores, up to two per cycle, enter
// in program order. They drain one at a time, oldest first, to memory over a
// valid/ack handshake. While a store waits here, a load can look up its
// quadword and receive the youngest buffered data for that quadword in the
// same cycle. Committed stores are architectural, so the buffer has no flush
// input. An entry leaves only when memory acknowledges it.
//
// Ports:
//   clock, reset         system clock; synchronous active-high reset
//   wb_in1_*             retired store 1 (older): valid, byte address, data
//   wb_in2_*             retired store 2 (younger): valid, byte address, data
//   wb_free_cnt          free entries (WB_SIZE - count), from registered state
//   wb_full, wb_empty    occupancy flags
//   mem_req_valid/addr/data  head entry offered to memory
//   mem_req_ack          memory accepts the head entry this cycle
//   ld_lookup_addr       load address to match against buffered stores
//   ld_fwd_hit/data      youngest quadword match and its data (0 on miss)

module store_write_buffer #(
  parameter int WB_SIZE = 8,
  parameter int PTR_W   = $clog2(WB_SIZE)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wb_in1_valid,
  input  logic [63:0]      wb_in1_addr,
  input  logic [63:0]      wb_in1_data,
  input  logic             wb_in2_valid,
  input  logic [63:0]      wb_in2_addr,
  input  logic [63:0]      wb_in2_data,
  output logic [PTR_W:0]   wb_free_cnt,
  output logic             wb_full,
  output logic             wb_empty,
  output logic             mem_req_valid,
  output logic [63:0]      mem_req_addr,
  output logic [63:0]      mem_req_data,
  input  logic             mem_req_ack,
  input  logic [63:0]      ld_lookup_addr,
  output logic             ld_fwd_hit,
  output logic [63:0]      ld_fwd_data
);

  logic [WB_SIZE-1:0] valid_q;
  logic [63:0]        addr_q [WB_SIZE];
  logic [63:0]        data_q [WB_SIZE];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [PTR_W:0]     count;

  logic               accept1;
  logic               accept2;
  logic               pop;
  logic [PTR_W:0]     push_cnt;
  logic [PTR_W-1:0]   wr_idx1;
  logic [PTR_W-1:0]   wr_idx2;
  logic [PTR_W-1:0]   fwd_idx;

  // The low three address bits select a byte within the quadword.
  // Forwarding matches whole quadwords, so these bits are ignored.
  logic               unused_lookup_bits;
  assign unused_lookup_bits = ^ld_lookup_addr[2:0];

  assign wb_free_cnt   = (PTR_W+1)'(WB_SIZE) - count;
  assign wb_full       = (count == (PTR_W+1)'(WB_SIZE));
  assign wb_empty      = (count == '0);
  assign mem_req_valid = ~wb_empty;

  // Gating with the empty flag keeps the request fields at zero after reset
  // and after a full drain, instead of showing stale head contents.
  assign mem_req_addr  = wb_empty ? 64'd0 : addr_q[head];
  assign mem_req_data  = wb_empty ? 64'd0 : data_q[head];

  assign pop = mem_req_ack & ~wb_empty;

  // Capacity uses the free space before this cycle's pop, so a full buffer
  // admits nothing even when an ack arrives in the same cycle. in1 has
  // priority. in2 needs a second free slot only when in1 is also pushing.
  assign accept1  = wb_in1_valid && (wb_free_cnt >= (PTR_W+1)'(1));
  assign accept2  = wb_in2_valid &&
                    (wb_free_cnt >= (wb_in1_valid ? (PTR_W+1)'(2) : (PTR_W+1)'(1)));
  assign push_cnt = (PTR_W+1)'(accept1) + (PTR_W+1)'(accept2);
  assign wr_idx1  = tail;
  assign wr_idx2  = tail + PTR_W'(accept1);

  always_ff @(posedge clock) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      // A push only targets free slots, so it never hits the head entry that
      // is popped in the same cycle.
      if (pop) begin
        valid_q[head] <= 1'b0;
        head          <= head + PTR_W'(1);
      end
      if (accept1) begin
        valid_q[wr_idx1] <= 1'b1;
        addr_q[wr_idx1]  <= wb_in1_addr;
        data_q[wr_idx1]  <= wb_in1_data;
      end
      if (accept2) begin
        valid_q[wr_idx2] <= 1'b1;
        addr_q[wr_idx2]  <= wb_in2_addr;
        data_q[wr_idx2]  <= wb_in2_data;
      end
      tail  <= tail + PTR_W'(push_cnt);
      count <= count + push_cnt - (PTR_W+1)'(pop);
    end
  end

  // Entries are scanned from oldest (head) to youngest, so the last match
  // wins and supplies the youngest data. The scan reads registered entries
  // only. Same-cycle pushes are therefore invisible, and an entry that is
  // acked this cycle still forwards.
  always_comb begin
    ld_fwd_hit  = 1'b0;
    ld_fwd_data = 64'd0;
    fwd_idx     = head;
    for (int i = 0; i < WB_SIZE; i++) begin
      fwd_idx = head + PTR_W'(i);
      if (valid_q[fwd_idx] && (addr_q[fwd_idx][63:3] == ld_lookup_addr[63:3])) begin
        ld_fwd_hit  = 1'b1;
        ld_fwd_data = data_q[fwd_idx];
      end
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer
//
// Directed bench for store_write_buffer (WB_SIZE = 8). Inputs change one time
// unit after the rising edge. Outputs are sampled between edges.

module tb_store_write_buffer;

  logic        clock;
  logic        reset;
  logic        wb_in1_valid;
  logic [63:0] wb_in1_addr;
  logic [63:0] wb_in1_data;
  logic        wb_in2_valid;
  logic [63:0] wb_in2_addr;
  logic [63:0] wb_in2_data;
  logic [3:0]  wb_free_cnt;
  logic        wb_full;
  logic        wb_empty;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_data;
  logic        mem_req_ack;
  logic [63:0] ld_lookup_addr;
  logic        ld_fwd_hit;
  logic [63:0] ld_fwd_data;

  int checks = 0;
  int errors = 0;

  store_write_buffer #(.WB_SIZE(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .wb_in1_valid   (wb_in1_valid),
    .wb_in1_addr    (wb_in1_addr),
    .wb_in1_data    (wb_in1_data),
    .wb_in2_valid   (wb_in2_valid),
    .wb_in2_addr    (wb_in2_addr),
    .wb_in2_data    (wb_in2_data),
    .wb_free_cnt    (wb_free_cnt),
    .wb_full        (wb_full),
    .wb_empty       (wb_empty),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_ack    (mem_req_ack),
    .ld_lookup_addr (ld_lookup_addr),
    .ld_fwd_hit     (ld_fwd_hit),
    .ld_fwd_data    (ld_fwd_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v1, input logic [63:0] a1, input logic [63:0] d1,
                               input logic v2, input logic [63:0] a2, input logic [63:0] d2,
                               input logic ack);
    wb_in1_valid = v1;
    wb_in1_addr  = a1;
    wb_in1_data  = d1;
    wb_in2_valid = v2;
    wb_in2_addr  = a2;
    wb_in2_data  = d2;
    mem_req_ack  = ack;
  endtask

  task automatic stepClock();
    @(posedge clock);
    #1;
    applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0);
  endtask

  task automatic lookup(input string tag, input logic [63:0] addr,
                        input logic exp_hit, input logic [63:0] exp_data);
    ld_lookup_addr = addr;
    #1;
    checkOutput({tag, "_hit"}, {63'd0, ld_fwd_hit}, {63'd0, exp_hit});
    checkOutput({tag, "_data"}, ld_fwd_data, exp_data);
  endtask

  initial begin
    reset          = 1'b1;
    ld_lookup_addr = 64'd0;
    applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset and idle state
    checkOutput("rst_empty", {63'd0, wb_empty}, 64'd1);
    checkOutput("rst_full", {63'd0, wb_full}, 64'd0);
    checkOutput("rst_free", {60'd0, wb_free_cnt}, 64'd8);
    checkOutput("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
    checkOutput("rst_req_addr", mem_req_addr, 64'd0);
    checkOutput("rst_req_data", mem_req_data, 64'd0);
    lookup("rst_lk0", 64'h0, 1'b0, 64'd0);
    lookup("rst_lk1000", 64'h1000, 1'b0, 64'd0);

    // An ack while empty is ignored
    applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b1);
    stepClock();
    checkOutput("empty_ack_free", {60'd0, wb_free_cnt}, 64'd8);

    // Dual push. The stores are not visible before the edge.
    applyStimulus(1'b1, 64'h1000, 64'hAA, 1'b1, 64'h2000, 64'hBB, 1'b0);
    lookup("same_cycle", 64'h1000, 1'b0, 64'd0);
    stepClock();
    checkOutput("dual_req_valid", {63'd0, mem_req_valid}, 64'd1);
    checkOutput("dual_req_addr", mem_req_addr, 64'h1000);
    checkOutput("dual_req_data", mem_req_data, 64'hAA);
    checkOutput("dual_free", {60'd0, wb_free_cnt}, 64'd6);
    lookup("dual_lk2000", 64'h2000, 1'b1, 64'hBB);
    applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b1);
    stepClock();
    checkOutput("ack1_req_addr", mem_req_addr, 64'h2000);
    checkOutput("ack1_req_data", mem_req_data, 64'hBB);
    checkOutput("ack1_free", {60'd0, wb_free_cnt}, 64'd7);
    applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b1);
    stepClock();
    checkOutput("ack2_empty", {63'd0, wb_empty}, 64'd1);
    checkOutput("ack2_req_valid", {63'd0, mem_req_valid}, 64'd0);

    // Fill all 8 entries starting at pointer 2. Entry j holds
    // {0x5000 + 8j, 0x100 + j}.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 64'h5000 + 64'(16 * k), 64'h100 + 64'(2 * k),
                    1'b1, 64'h5008 + 64'(16 * k), 64'h101 + 64'(2 * k), 1'b0);
      stepClock();
    end
    checkOutput("fill_full", {63'd0, wb_full}, 64'd1);
    checkOutput("fill_free", {60'd0, wb_free_cnt}, 64'd0);
    checkOutput("fill_head_addr", mem_req_addr, 64'h5000);

    // A full buffer drops the push even with a same-cycle ack
    applyStimulus(1'b1, 64'h9000, 64'hDEAD, 1'b0, 64'd0, 64'd0, 1'b1);
    stepClock();
    checkOutput("full_pp_free", {60'd0, wb_free_cnt}, 64'd1);
    checkOutput("full_pp_full", {63'd0, wb_full}, 64'd0);
    lookup("full_pp_dropped", 64'h9000, 1'b0, 64'd0);
    for (int j = 1; j < 8; j++) begin
      checkOutput($sformatf("drain%0d_addr", j), mem_req_addr, 64'h5000 + 64'(8 * j));
      checkOutput($sformatf("drain%0d_data", j), mem_req_data, 64'h100 + 64'(j));
      applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b1);
      stepClock();
    end
    checkOutput("drain_empty", {63'd0, wb_empty}, 64'd1);
    checkOutput("drain_free", {60'd0, wb_free_cnt}, 64'd8);

    // Same-quadword forwarding. The younger store arrives by an in2-only push.
    applyStimulus(1'b1, 64'h3000, 64'h11, 1'b0, 64'd0, 64'd0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 64'd0, 64'd0, 1'b1, 64'h3004, 64'h22, 1'b0);
    stepClock();
    checkOutput("fwd_free", {60'd0, wb_free_cnt}, 64'd6);
    lookup("fwd_lk3000", 64'h3000, 1'b1, 64'h22);
    lookup("fwd_lk3007", 64'h3007, 1'b1, 64'h22);
    lookup("fwd_lk3008", 64'h3008, 1'b0, 64'd0);
    lookup("fwd_lk2ff8", 64'h2FF8, 1'b0, 64'd0);
    applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b1);
    stepClock();
    checkOutput("in2only_req_addr", mem_req_addr, 64'h3004);
    // An entry acked this cycle still forwards
    applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b1);
    lookup("ack_fwd", 64'h3000, 1'b1, 64'h22);
    stepClock();
    lookup("post_ack_fwd", 64'h3000, 1'b0, 64'd0);

    // Partial acceptance when free = 1 and both inputs are valid
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 64'h6000 + 64'(16 * k), 64'h600 + 64'(2 * k),
                    1'b1, 64'h6008 + 64'(16 * k), 64'h601 + 64'(2 * k), 1'b0);
      stepClock();
    end
    applyStimulus(1'b1, 64'h6030, 64'h606, 1'b0, 64'd0, 64'd0, 1'b0);
    stepClock();
    checkOutput("pre_partial_free", {60'd0, wb_free_cnt}, 64'd1);
    applyStimulus(1'b1, 64'h40, 64'h1, 1'b1, 64'h48, 64'h2, 1'b0);
    stepClock();
    checkOutput("partial_free", {60'd0, wb_free_cnt}, 64'd0);
    checkOutput("partial_full", {63'd0, wb_full}, 64'd1);
    lookup("partial_lk40", 64'h40, 1'b1, 64'h1);
    lookup("partial_lk48", 64'h48, 1'b0, 64'd0);

    // Reset in mid-drain with five entries left
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b1);
      stepClock();
    end
    checkOutput("mid_free", {60'd0, wb_free_cnt}, 64'd3);
    checkOutput("mid_req_valid", {63'd0, mem_req_valid}, 64'd1);
    checkOutput("mid_req_addr", mem_req_addr, 64'h6018);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("mid_rst_empty", {63'd0, wb_empty}, 64'd1);
    checkOutput("mid_rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
    checkOutput("mid_rst_free", {60'd0, wb_free_cnt}, 64'd8);
    lookup("mid_rst_lk40", 64'h40, 1'b0, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
